// File: rtl/sha256_spi_frontend.sv
// SPI mode-3 slave front end for the SHA-256 register file.
// SCK, SS_n and MOSI are oversampled in i_clk. Each 16-bit frame {n_r_w, addr, data} becomes one
// write or read strobe. Read data is returned on MISO during the following frame.
module sha256_spi_frontend #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sck,
    input  logic              i_ss_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_frame_err
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned FILL_W  = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {StWaitIdle, StIdle, StShift, StCommit, StWaitSs} state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   shift_rx_q, shift_rx_d;
    logic [FRAME_W-1:0]   shift_tx_q, shift_tx_d;
    logic                 miso_q, miso_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]    last_rd_addr_q, last_rd_addr_d;
    logic [DATA_W-1:0]    tx_hold_q, tx_hold_d;

    logic sck_rise, sck_fall, ss_n_s, mosi_s, frame_done;

    // Synchroniser chains; index 0 is the newest sample.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    end

    // Edge detect on the last two synchroniser stages.
    always_comb begin
        sck_rise = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
        sck_fall = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
        ss_n_s   = ss_sync_q[SYNC_STAGES-1];
        mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    end

    // Frame FSM: next state, shift registers and strobes.
    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        bit_cnt_d      = bit_cnt_q;
        shift_rx_d     = shift_rx_q;
        shift_tx_d     = shift_tx_q;
        miso_d         = miso_q;
        wr_en_d        = 1'b0;
        rd_en_d        = 1'b0;
        frame_err_d    = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        last_rd_addr_d = last_rd_addr_q;
        rd_pend_d      = rd_en_q;
        tx_hold_d      = rd_pend_q ? i_rdata : tx_hold_q;
        frame_done     = 1'b0;

        unique case (state_q)
            StWaitIdle: begin
                miso_d = 1'b0;
                // The chains reset to "deselected"; wait until they hold real pin samples so a
                // reset released mid-frame cannot be mistaken for an idle bus.
                if (fill_q != FILL_W'(SYNC_STAGES)) begin
                    fill_d = fill_q + FILL_W'(1);
                end else if (ss_n_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                miso_d = 1'b0;
                if (!ss_n_s) begin
                    state_d    = StShift;
                    bit_cnt_d  = '0;
                    shift_tx_d = {1'b0, last_rd_addr_q, tx_hold_q};
                end
            end
            StShift: begin
                if (sck_rise) begin
                    shift_rx_d = {shift_rx_q[FRAME_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        frame_done = 1'b1;
                        state_d    = StCommit;
                        addr_d     = shift_rx_d[FRAME_W-2:DATA_W];
                        if (shift_rx_d[FRAME_W-1]) begin
                            wr_en_d = 1'b1;
                            wdata_d = shift_rx_d[DATA_W-1:0];
                        end else begin
                            rd_en_d        = 1'b1;
                            last_rd_addr_d = shift_rx_d[FRAME_W-2:DATA_W];
                        end
                    end
                end
                if (sck_fall) begin
                    miso_d     = shift_tx_q[FRAME_W-1];
                    shift_tx_d = {shift_tx_q[FRAME_W-2:0], 1'b0};
                end
                // A completing 16th edge wins over a simultaneous deselect.
                if (!frame_done && ss_n_s) begin
                    state_d     = StIdle;
                    miso_d      = 1'b0;
                    frame_err_d = (bit_cnt_d != '0);
                end
            end
            StCommit: begin
                state_d = StWaitSs;
            end
            StWaitSs: begin
                if (ss_n_s) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            end
            default: state_d = StWaitIdle;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StWaitIdle;
            sck_sync_q     <= '1;
            ss_sync_q      <= '1;
            mosi_sync_q    <= '0;
            fill_q         <= '0;
            bit_cnt_q      <= '0;
            shift_rx_q     <= '0;
            shift_tx_q     <= '0;
            miso_q         <= 1'b0;
            wr_en_q        <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_pend_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            last_rd_addr_q <= '0;
            tx_hold_q      <= '0;
        end else begin
            state_q        <= state_d;
            sck_sync_q     <= sck_sync_d;
            ss_sync_q      <= ss_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            fill_q         <= fill_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_rx_q     <= shift_rx_d;
            shift_tx_q     <= shift_tx_d;
            miso_q         <= miso_d;
            wr_en_q        <= wr_en_d;
            rd_en_q        <= rd_en_d;
            rd_pend_q      <= rd_pend_d;
            frame_err_q    <= frame_err_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            last_rd_addr_q <= last_rd_addr_d;
            tx_hold_q      <= tx_hold_d;
        end
    end

    assign o_spi_miso  = miso_q;
    assign o_wr_en     = wr_en_q;
    assign o_rd_en     = rd_en_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_sha256_spi_frontend.sv
// Bench for sha256_spi_frontend: an SPI master drives frames, a frame-level model predicts the
// strobe sequence and the returned MISO word, and a per-cycle monitor checks the DUT against it.
`timescale 1ns/1ps
module tb_sha256_spi_frontend;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       miso, wr_en, rd_en, frame_err;
    logic [6:0] addr;
    logic [7:0] wdata;

    always #25 clk = ~clk;  // 20 MHz

    sha256_spi_frontend dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sck       (sck),
        .i_ss_n      (ss_n),
        .i_spi_mosi  (mosi),
        .o_spi_miso  (miso),
        .o_wr_en     (wr_en),
        .o_rd_en     (rd_en),
        .o_addr      (addr),
        .o_wdata     (wdata),
        .i_rdata     (rdata),
        .o_frame_err (frame_err)
    );

    // Expected strobe: kind 0 = write, 1 = read, 2 = frame error.
    typedef struct packed {
        logic [1:0] kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur_ev;
    logic [1:0] act_kind;
    int         n_checks = 0;
    int         n_fail = 0;
    int         hi_cnt = 0;
    int         err_seen = 0;
    logic [7:0] env_mem[128];
    logic [7:0] model_mem[128];
    logic [6:0] m_last_rd = 7'd0;
    logic [7:0] m_tx_hold = 8'd0;
    logic [15:0] rx_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Downstream register file: writes land, read data appears the cycle after o_rd_en.
    always @(posedge clk) begin
        if (wr_en) env_mem[addr] <= wdata;
        if (rd_en) rdata <= env_mem[addr];
    end

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_wr_en", 32'(wr_en), 32'd0);
            check("reset_rd_en", 32'(rd_en), 32'd0);
            check("reset_frame_err", 32'(frame_err), 32'd0);
            check("reset_miso", 32'(miso), 32'd0);
        end else begin
            hi_cnt = ss_n ? hi_cnt + 1 : 0;
            if (hi_cnt >= 8) check("miso_deselected", 32'(miso), 32'd0);
            if (wr_en || rd_en || frame_err) begin
                check("single_strobe", 32'(wr_en) + 32'(rd_en) + 32'(frame_err), 32'd1);
                act_kind = wr_en ? 2'd0 : (rd_en ? 2'd1 : 2'd2);
                if (frame_err) err_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: kind %0d addr %0h at %0t", act_kind, addr,
                             $time);
                end else begin
                    cur_ev = exp_q.pop_front();
                    check("strobe_kind", 32'(act_kind), 32'(cur_ev.kind));
                    if (cur_ev.kind != 2'd2) check("strobe_addr", 32'(addr), 32'(cur_ev.addr));
                    if (cur_ev.kind == 2'd0) check("strobe_wdata", 32'(wdata), 32'(cur_ev.data));
                end
            end
        end
    end

    // SPI mode-3 master at 2 MHz; optional reset pulse before the rise of bit rst_at.
    task automatic spi_frame(input logic [15:0] frame, input int nbits, input int rst_at,
                             output logic [15:0] rx);
        rx = '0;
        ss_n = 1'b0;
        #300;
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            mosi = (i < 16) ? frame[15-i] : 1'($urandom);
            #250;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #60;
                rst_n = 1'b1;
            end
            sck = 1'b1;
            if (i < 16) rx[15-i] = miso;
            #250;
        end
        #300;
        ss_n = 1'b1;
        #700;
    endtask

    // Frame-level model: one strobe per complete frame, an error for a short one.
    task automatic do_frame(input logic [15:0] frame, input int nbits, input int rst_at);
        logic [15:0] exp_miso;
        logic [6:0]  a;
        logic [7:0]  d;
        ev_t         e;
        a = frame[14:8];
        d = frame[7:0];
        exp_miso = {1'b0, m_last_rd, m_tx_hold};
        if (rst_at >= 0 && rst_at < nbits) begin
            m_last_rd = '0;
            m_tx_hold = '0;
        end else if (nbits >= 16) begin
            e.kind = frame[15] ? 2'd0 : 2'd1;
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
            if (frame[15]) begin
                model_mem[a] = d;
            end else begin
                m_last_rd = a;
                m_tx_hold = model_mem[a];
            end
        end else if (nbits > 0) begin
            e = '{kind: 2'd2, addr: 7'd0, data: 8'd0};
            exp_q.push_back(e);
        end
        spi_frame(frame, nbits, rst_at, rx_word);
        if (nbits >= 16 && !(rst_at >= 0 && rst_at < nbits)) check("miso_word", 32'(rx_word),
                                                                   32'(exp_miso));
        check("strobes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          e0;
        logic [7:0]  msg[64];
        logic [15:0] f;
        int          nb, ra, r;

        for (int i = 0; i < 128; i++) begin
            env_mem[i] = 8'($urandom);
            model_mem[i] = env_mem[i];
        end
        env_mem[70] = 8'hBA;
        model_mem[70] = 8'hBA;

        #110;
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_wdata", 32'(wdata), 32'd0);
        rst_n = 1'b1;
        #500;

        // Single write.
        do_frame({1'b1, 7'd5, 8'hA5}, 16, -1);
        check("t1_addr", 32'(addr), 32'd5);
        check("t1_wdata", 32'(wdata), 32'hA5);

        // Padded "abc" message block into 0..63, then start bit at 65.
        for (int i = 0; i < 64; i++) msg[i] = 8'h00;
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
        msg[3] = 8'h80;
        msg[63] = 8'h18;
        for (int i = 0; i < 64; i++) do_frame({1'b1, 7'(i), msg[i]}, 16, -1);
        do_frame({1'b1, 7'd65, 8'h01}, 16, -1);
        check("t2_msg3", 32'(env_mem[3]), 32'h80);
        check("t2_msg63", 32'(env_mem[63]), 32'h18);

        // Two-frame read of the first digest byte.
        do_frame({1'b0, 7'd70, 8'h00}, 16, -1);
        do_frame({1'b1, 7'd20, 8'h11}, 16, -1);
        check("t3_miso_literal", 32'(rx_word), 32'h46BA);

        // Aborted frame after 9 edges, then a clean frame.
        e0 = err_seen;
        do_frame({1'b1, 7'd7, 8'h77}, 9, -1);
        check("t4_err_pulses", 32'(err_seen - e0), 32'd1);
        do_frame({1'b1, 7'd8, 8'h88}, 16, -1);
        check("t4_next_addr", 32'(addr), 32'd8);

        // Reset during bit 6 with SS_n held low; that frame must vanish.
        do_frame({1'b1, 7'd4, 8'h44}, 16, 6);
        check("t5_after_reset_addr", 32'(addr), 32'd0);
        do_frame({1'b1, 7'd3, 8'h5A}, 16, -1);
        check("t5_addr", 32'(addr), 32'd3);
        check("t5_wdata", 32'(wdata), 32'h5A);

        // Over-long frame: extra edges are ignored.
        do_frame({1'b1, 7'd9, 8'h3C}, 18, -1);
        check("t6_addr", 32'(addr), 32'd9);
        check("t6_wdata", 32'(wdata), 32'h3C);

        // Randomised mix of reads, writes, short, long and reset-interrupted frames.
        for (int n = 0; n < 40; n++) begin
            f = 16'($urandom);
            if (n % 5 == 0) f[14:8] = 7'd70;
            r = $urandom_range(0, 9);
            nb = 16;
            ra = -1;
            if (r == 7) nb = $urandom_range(0, 15);
            else if (r == 8) nb = $urandom_range(17, 18);
            else if (r == 9) ra = $urandom_range(0, 15);
            do_frame(f, nb, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
